// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: clocked response checker for an SR latch under test.
// Synchronizes the latch pins, tracks a reference model of the latch state
// and reports mismatches, non-complementary outputs and forbidden inputs.
// Optional build macro SR_MON_COVER_EN adds the cov_bits coverage output.
module sr_latch_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             model_q,
  output logic             model_valid,
  output logic             forbidden,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt
`ifdef SR_MON_COVER_EN
  ,
  output logic [3:0]       cov_bits
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD   = CW'(SETTLE_CYCLES);
  // The cycle that exposes a change already carries the new value, so it
  // counts as the first settle cycle after a change.
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, TRACK, FORBID} state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [3:0]      sync_chain [SYNC_STAGES];
  logic [3:0]      synced;
  logic [1:0]      sr;
  logic [1:0]      sr_prev;
  logic            q_s;
  logic            qbar_s;
  logic            change;
  logic            settle_done;
  logic            after_forbid;
  logic            reported;
  logic            err_event;
  logic [1:0]      event_code;

  // Bit order in the chain: {s, r, q, qbar}
  assign synced = sync_chain[SYNC_STAGES-1];
  assign sr     = synced[3:2];
  assign q_s    = synced[1];
  assign qbar_s = synced[0];
  assign change = (sr != sr_prev);
  assign settle_done = en && (state == SETTLE) && !change && (settle_cnt <= ONE);

  // Pin synchronizers plus the previous synced {s,r} for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
      sr_prev <= 2'b00;
    end else begin
      sync_chain[0] <= {s_in, r_in, q_in, qbar_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
      sr_prev <= sr;
    end
  end

  // Error detection: forbidden entry, then TRACK compares (a change wins)
  always_comb begin
    err_event  = 1'b0;
    event_code = 2'b00;
    if (settle_done && (sr == 2'b11)) begin
      err_event  = 1'b1;
      event_code = 2'b11;
    end else if (en && (state == TRACK) && !change && !reported) begin
      if (q_s == qbar_s) begin
        err_event  = 1'b1;
        event_code = 2'b10;
      end else if (model_valid && (q_s != model_q)) begin
        err_event  = 1'b1;
        event_code = 2'b01;
      end
    end
  end

  // Monitor FSM with the reference latch model and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      forbidden    <= 1'b0;
      model_q      <= 1'b0;
      model_valid  <= 1'b0;
      after_forbid <= 1'b0;
      reported     <= 1'b0;
    end else begin
      if (change) reported <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        settle_cnt <= '0;
        forbidden  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= LOAD;
          end
          SETTLE: begin
            if (change) begin
              settle_cnt <= RELOAD;
            end else if (settle_cnt > ONE) begin
              settle_cnt <= settle_cnt - ONE;
            end else begin
              settle_cnt <= '0;
              if (sr == 2'b11) begin
                state        <= FORBID;
                forbidden    <= 1'b1;
                after_forbid <= 1'b1;
              end else begin
                state        <= TRACK;
                after_forbid <= 1'b0;
                reported     <= 1'b0;
                case (sr)
                  2'b10: begin
                    model_q     <= 1'b1;
                    model_valid <= 1'b1;
                  end
                  2'b01: begin
                    model_q     <= 1'b0;
                    model_valid <= 1'b1;
                  end
                  // Leaving s=r=1 for hold is a race: state unknown
                  default: if (after_forbid) model_valid <= 1'b0;
                endcase
              end
            end
          end
          TRACK: begin
            if (change) begin
              state      <= SETTLE;
              settle_cnt <= RELOAD;
            end else if (err_event) begin
              reported <= 1'b1;
            end
          end
          FORBID: begin
            if (change) begin
              state      <= SETTLE;
              settle_cnt <= RELOAD;
              forbidden  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Error reporting: pulse, sticky flag, last code and saturating count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_code   <= 2'b00;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_event;
      if (err_event) begin
        err_sticky <= 1'b1;
        err_code   <= event_code;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SR_MON_COVER_EN
  // Coverage: mark each stable {s,r} combination that reaches TRACK/FORBID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_bits <= 4'b0000;
    end else if (settle_done) begin
      cov_bits[sr] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_latch_monitor.sv
// tb_sr_latch_monitor: directed scenarios plus randomized pin activity for
// sr_latch_monitor, checked against a history-based reference model.
module tb_sr_latch_monitor;

  localparam int SYNC   = 2;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             s_in = 1'b0;
  logic             r_in = 1'b0;
  logic             q_in = 1'b0;
  logic             qbar_in = 1'b1;
  logic             model_q;
  logic             model_valid;
  logic             forbidden;
  logic             err_pulse;
  logic             err_sticky;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_cnt;
`ifdef SR_MON_COVER_EN
  logic [3:0]       cov_bits;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  sr_latch_monitor #(
    .SYNC_STAGES  (SYNC),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_in       (s_in),
    .r_in       (r_in),
    .q_in       (q_in),
    .qbar_in    (qbar_in),
    .model_q    (model_q),
    .model_valid(model_valid),
    .forbidden  (forbidden),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_code   (err_code),
    .err_cnt    (err_cnt)
`ifdef SR_MON_COVER_EN
    ,
    .cov_bits   (cov_bits)
`endif
  );

  // Reference model: pin history, stability run lengths, expected outputs
  logic [3:0]       hist [0:SYNC];
  int               en_run;
  int               quiet;
  bit               was_settled;
  bit               after_forbid;
  bit               reported;
  bit               x_q;
  bit               x_v;
  bit               x_forb;
  bit               x_pulse;
  bit               x_sticky;
  logic [1:0]       x_code;
  logic [CNT_W-1:0] x_cnt;

  task automatic model_reset();
    for (int i = 0; i <= SYNC; i++) hist[i] = 4'b0000;
    en_run = 0; quiet = 0;
    was_settled = 0; after_forbid = 0; reported = 0;
    x_q = 0; x_v = 0; x_forb = 0; x_pulse = 0; x_sticky = 0;
    x_code = 2'b00; x_cnt = '0;
  endtask

  task automatic model_raise(input logic [1:0] c);
    x_pulse  = 1;
    x_code   = c;
    x_sticky = 1;
    if (x_cnt != '1) x_cnt = x_cnt + 1'b1;
  endtask

  // One clock edge of the model. The monitor sees pins SYNC edges late.
  task automatic model_step();
    logic [3:0] syn;
    logic [3:0] prv;
    logic [1:0] sr;
    logic       chg;
    logic       now_s;
    syn = hist[SYNC-1];
    prv = hist[SYNC];
    sr  = syn[3:2];
    chg = (syn[3:2] != prv[3:2]);
    if (en) begin
      if (en_run < 1000) en_run++;
    end else begin
      en_run = 0;
    end
    if (chg) quiet = 0;
    else if (quiet < 1000) quiet++;
    // Settled: enabled for a full settle window plus the enable cycle, and
    // quiet for the settle window counted from the cycle showing the change.
    now_s = (en_run >= SETTLE + 1) && (quiet >= ((SETTLE > 1) ? SETTLE - 1 : 1));
    x_pulse = 0;
    if (chg) reported = 0;
    if (now_s && !was_settled) begin
      if (sr == 2'b11) begin
        after_forbid = 1;
        model_raise(2'b11);
      end else begin
        if (sr == 2'b10) begin x_q = 1; x_v = 1; end
        else if (sr == 2'b01) begin x_q = 0; x_v = 1; end
        else if (after_forbid) x_v = 0;
        after_forbid = 0;
        reported = 0;
      end
    end else if (now_s && sr != 2'b11 && !reported) begin
      if (syn[1] == syn[0]) begin
        model_raise(2'b10);
        reported = 1;
      end else if (x_v && syn[1] != x_q) begin
        model_raise(2'b01);
        reported = 1;
      end
    end
    x_forb = now_s && (sr == 2'b11);
    was_settled = now_s;
    for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {s_in, r_in, q_in, qbar_in};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (err_pulse === 1'b1) pulses++;
  endtask

  task automatic drive(input logic s, input logic r, input logic q, input logic qb);
    s_in = s; r_in = r; q_in = q; qbar_in = qb;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    drive(0, 0, 0, 1);
    model_reset();
    #1;
    n_checks++;
    if ({model_q, model_valid, forbidden, err_pulse, err_sticky, err_code, err_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {model_q, model_valid, forbidden, err_pulse, err_sticky, err_code, err_cnt});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    pulses = 0;
    repeat (20) tick();
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("FAIL hold_pulses: got %0d required 0", pulses); end
    n_checks++;
    if (model_valid !== 1'b0) begin n_errors++; $display("FAIL hold_valid: got %b required 0", model_valid); end
    n_checks++;
    if (err_cnt !== '0) begin n_errors++; $display("FAIL hold_cnt: got %0d required 0", err_cnt); end
    $display("test_reset done: checks=%0d", n_checks);
  endtask

  task automatic test_set_reset();
    pulses = 0;
    drive(1, 0, 1, 0);
    repeat (10) tick();
    n_checks++;
    if ({model_q, model_valid} !== 2'b11) begin n_errors++; $display("FAIL set_model: got q=%b v=%b required q=1 v=1", model_q, model_valid); end
    drive(0, 1, 0, 1);
    repeat (10) tick();
    n_checks++;
    if ({model_q, model_valid} !== 2'b01) begin n_errors++; $display("FAIL reset_model: got q=%b v=%b required q=0 v=1", model_q, model_valid); end
    n_checks++;
    if (pulses != 0 || err_cnt !== '0) begin n_errors++; $display("FAIL setreset_errors: got pulses=%0d cnt=%0d required 0", pulses, err_cnt); end
    $display("test_set_reset done: checks=%0d", n_checks);
  endtask

  task automatic test_stuck();
    int k_hit;
    drive(1, 0, 1, 0);
    repeat (10) tick();
    pulses = 0; k_hit = 0;
    drive(0, 0, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (err_pulse === 1'b1 && k_hit == 0) k_hit = k;
    end
    n_checks++;
    if (k_hit != SYNC + SETTLE + 1) begin n_errors++; $display("FAIL stuck_latency: got %0d required %0d", k_hit, SYNC + SETTLE + 1); end
    n_checks++;
    if (err_code !== 2'b01) begin n_errors++; $display("FAIL stuck_code: got %b required 01", err_code); end
    n_checks++;
    if (err_cnt !== 2'd1) begin n_errors++; $display("FAIL stuck_cnt: got %0d required 1", err_cnt); end
    repeat (10) tick();
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL stuck_once: got %0d pulses required 1", pulses); end
    $display("test_stuck done: checks=%0d", n_checks);
  endtask

  task automatic test_forbidden();
    bit seen;
    pulses = 0; seen = 0;
    drive(1, 1, 0, 1);
    repeat (10) begin
      tick();
      if (forbidden === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL forbid_flag: got 0 required 1"); end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL forbid_pulses: got %0d required 1", pulses); end
    n_checks++;
    if (err_code !== 2'b11) begin n_errors++; $display("FAIL forbid_code: got %b required 11", err_code); end
    drive(0, 0, 0, 1);
    repeat (10) tick();
    n_checks++;
    if ({model_valid, forbidden} !== 2'b00) begin n_errors++; $display("FAIL forbid_exit: got v=%b forbidden=%b required 0 0", model_valid, forbidden); end
    $display("test_forbidden done: checks=%0d", n_checks);
  endtask

  task automatic test_saturation();
    pulses = 0;
    for (int e = 0; e < 5; e++) begin
      if (e % 2 == 0) drive(1, 0, 1, 1);
      else drive(0, 1, 1, 1);
      repeat (8) tick();
    end
    n_checks++;
    if (pulses != 5) begin n_errors++; $display("FAIL sat_pulses: got %0d required 5", pulses); end
    n_checks++;
    if (err_code !== 2'b10) begin n_errors++; $display("FAIL sat_code: got %b required 10", err_code); end
    n_checks++;
    if (err_cnt !== 2'd3) begin n_errors++; $display("FAIL sat_cnt: got %0d required 3", err_cnt); end
    n_checks++;
    if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL sat_sticky: got %b required 1", err_sticky); end
    $display("test_saturation done: checks=%0d", n_checks);
  endtask

  task automatic test_glitch_reset();
    logic s;
    s = s_in;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      drive(s, r_in, 1, 1);
      tick();
    end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("FAIL glitch_pulses: got %0d required 0", pulses); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({model_q, model_valid, forbidden, err_pulse, err_sticky, err_code, err_cnt} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got %b required all zero",
               {model_q, model_valid, forbidden, err_pulse, err_sticky, err_code, err_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_glitch_reset done: checks=%0d", n_checks);
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 70; seg++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) qbar_in = ~q_in;
      en = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 8);
      repeat (hold) begin
        tick();
        n_checks++;
        if (err_pulse !== x_pulse) begin n_errors++; $display("FAIL rnd_pulse: got %b required %b at %0t", err_pulse, x_pulse, $time); end
        n_checks++;
        if (err_code !== x_code) begin n_errors++; $display("FAIL rnd_code: got %b required %b at %0t", err_code, x_code, $time); end
        n_checks++;
        if (err_cnt !== x_cnt) begin n_errors++; $display("FAIL rnd_cnt: got %0d required %0d at %0t", err_cnt, x_cnt, $time); end
        n_checks++;
        if (err_sticky !== x_sticky) begin n_errors++; $display("FAIL rnd_sticky: got %b required %b at %0t", err_sticky, x_sticky, $time); end
        n_checks++;
        if (forbidden !== x_forb) begin n_errors++; $display("FAIL rnd_forbidden: got %b required %b at %0t", forbidden, x_forb, $time); end
        n_checks++;
        if (model_valid !== x_v) begin n_errors++; $display("FAIL rnd_valid: got %b required %b at %0t", model_valid, x_v, $time); end
        n_checks++;
        if (model_valid === 1'b1 && model_q !== x_q) begin n_errors++; $display("FAIL rnd_model_q: got %b required %b at %0t", model_q, x_q, $time); end
      end
    end
    en = 1'b1;
    $display("test_random done: checks=%0d", n_checks);
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_stuck();
    test_forbidden();
    test_saturation();
    test_glitch_reset();
    en = 1'b1;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_monitor.md
Name: sr_latch_monitor

Overview:
- Clocked response checker for an SR latch under test. It samples the latch inputs (s, r) and outputs (q, qbar) through synchronizers and keeps a reference model of the latch state.
- It flags mismatches, non-complementary outputs and forbidden input combinations. Error status is reported as pulse, sticky flag, code and saturating count.
- It sits beside a latch instance, in a bench or a BIST wrapper, as the observing end of the stimulus interface.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on each of s_in, r_in, q_in, qbar_in; minimum 2.
- SETTLE_CYCLES, 2: synced cycles the inputs must stay stable before outputs are compared; minimum 1.
- CNT_W, 8: width of err_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  monitor enable; 0 forces IDLE
- s_in  input  1  latch set input (async)
- r_in  input  1  latch reset input (async)
- q_in  input  1  latch q output (async)
- qbar_in  input  1  latch qbar output (async)
- model_q  output  1  reference-model state
- model_valid  output  1  model state is known
- forbidden  output  1  synced s=r=1 currently held
- err_pulse  output  1  one-cycle pulse per error event
- err_sticky  output  1  set on any error, cleared only by rst
- err_code  output  2  last error: 00 none, 01 q mismatch, 10 q==qbar, 11 forbidden input
- err_cnt  output  CNT_W  error event count, saturating

Behaviour:
- Reset (async, rst=1): all outputs are 0, FSM goes to IDLE, synchronizers and settle counter are 0.
- Synchronizers: SYNC_STAGES flops per input. s/r "change" means the synced {s,r} differs from its value registered the previous cycle.
- FSM states: IDLE, SETTLE, TRACK, FORBID.
- IDLE:
  - Entered whenever en=0, from any state; model state is kept.
  - en=1 -> SETTLE with counter=SETTLE_CYCLES.
- SETTLE:
  - Counter decrements each cycle; no compares.
  - Any change reloads the counter.
  - Counter reaching 0: go to FORBID if synced s&r, else TRACK.
- TRACK:
  - Compare every cycle; any change -> SETTLE.
- FORBID:
  - forbidden=1; no compares.
  - On entry, raise a code-11 error once.
  - Any change -> SETTLE.
- Model update, on the SETTLE->TRACK transition, using synced {s,r}:
  - 10: model_q=1, model_valid=1.
  - 01: model_q=0, model_valid=1.
  - 00: hold, except after FORBID, where model_valid=0 (race, state unknown).
  - 11: model_valid unchanged.
- TRACK checks (priority order):
  - q==qbar -> code 10; checked even if model_valid=0.
  - Else, if model_valid and q!=model_q -> code 01.
- Error event behaviour:
  - Report at most once per stable TRACK period; a "reported" flag clears on the next change.
  - Event actions: err_pulse=1 for one cycle, err_code updated, err_sticky=1, err_cnt+1 saturating at all-ones.
- Latency: pin change to err_pulse = SYNC_STAGES + SETTLE_CYCLES + 1 clocks (5 at defaults).
- Simultaneous events: a change in the same cycle as a TRACK compare suppresses the compare (the change wins).
- en falling mid-SETTLE: the counter is discarded; re-enable restarts the full settle.

Optional Feature:
- Macro: SR_MON_COVER_EN.
- Defined:
  - Adds output cov_bits, 4 bits, one sticky bit per stable input combination reached in TRACK/FORBID: bit0=00, bit1=01, bit2=10, bit3=11.
  - cov_bits is cleared by rst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then hold: rst=1 then 0, en=1, s=r=0, q=0, qbar=1 for 20 cycles -> model_valid=0, err_pulse never 1, err_cnt=0.
- Good set/reset: s=1,r=0 with q=1,qbar=0; then s=0,r=1 with q=0,qbar=1 -> model_q follows 1 then 0, model_valid=1, no errors.
- Stuck output: after a valid set (model_q=1), drive s=r=0 with q=0, qbar=1 -> single err_pulse 5 cycles after the input change, err_code=01, err_cnt=1, no repeat while stable.
- Forbidden: s=r=1 for 10 cycles, then s=r=0 -> forbidden=1, exactly one pulse, err_code=11; after returning to 00, model_valid=0 and forbidden=0.
- Non-complement plus saturation (CNT_W=2): 5 separate q=qbar=1 events, each separated by an s/r change -> err_code=10, err_cnt stays at 3, err_sticky=1.
- Glitch/async reset: toggle s every cycle for 6 cycles -> FSM stays in SETTLE with no compares; assert rst mid-SETTLE -> all outputs 0 immediately, before the next clk edge.
